// File: rtl/trap_ctrl_if.sv
// CSR file access bundle between the trap sequencer (master) and the CSR file (slave).
// Signal names match the original flat port names so existing wiring maps across one-to-one.
interface trap_ctrl_if;
    logic [11:0] csr_raddr_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_rdata_i;

    modport master (
        output csr_raddr_o,
        output csr_waddr_o,
        output csr_wdata_o,
        input  csr_rdata_i
    );

    modport slave (
        input  csr_raddr_o,
        input  csr_waddr_o,
        input  csr_wdata_o,
        output csr_rdata_i
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: passes pipeline CSR traffic through in IDLE, otherwise owns the CSR
// ports to save/restore mepc/mcause/mstatus and emits a one-cycle PC redirect.
module trap_ctrl #(
    parameter logic [11:0] CSR_NONE    = 12'h000,
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MTVEC   = 12'h305,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_valid_i,
    input  logic [3:0]         exc_cause_i,
    input  logic [31:0]        exc_pc_i,
    input  logic               mret_i,
    input  logic [11:0]        ex_csr_raddr_i,
    input  logic [11:0]        ex_csr_waddr_i,
    input  logic [31:0]        ex_csr_wdata_i,
    trap_ctrl_if.master        csr,
    output logic               stall_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o
);

    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_STAT, T_REDIR, R_STAT, R_EPC, R_REDIR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc_q;
    logic [3:0]  r_cause_q;
    logic [31:0] r_stat_q;
    logic [31:0] r_vec_q;
    logic [31:0] w_trap_stat;
    logic [31:0] w_mret_stat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc_q    <= '0;
            r_cause_q <= '0;
            r_stat_q  <= '0;
            r_vec_q   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (exc_valid_i) begin
                        r_pc_q    <= exc_pc_i;
                        r_cause_q <= exc_cause_i;
                    end
                end
                T_EPC:   r_stat_q <= csr.csr_rdata_i;
                T_CAUSE: r_vec_q  <= csr.csr_rdata_i;
                R_STAT:  r_stat_q <= csr.csr_rdata_i;
                R_EPC:   r_pc_q   <= csr.csr_rdata_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_trap_stat        = r_stat_q;
        w_trap_stat[7]     = r_stat_q[3];
        w_trap_stat[3]     = 1'b0;
        w_trap_stat[12:11] = 2'b11;

        w_mret_stat        = r_stat_q;
        w_mret_stat[3]     = r_stat_q[7];
        w_mret_stat[7]     = 1'b1;
        w_mret_stat[12:11] = 2'b11;
    end

    always_comb begin
        w_next          = r_state;
        csr.csr_raddr_o = CSR_NONE;
        csr.csr_waddr_o = CSR_NONE;
        csr.csr_wdata_o = '0;
        stall_o         = 1'b1;
        redirect_o      = 1'b0;
        redirect_pc_o   = '0;

        case (r_state)
            IDLE: begin
                csr.csr_raddr_o = ex_csr_raddr_i;
                csr.csr_wdata_o = ex_csr_wdata_i;
                csr.csr_waddr_o = (exc_valid_i || mret_i) ? CSR_NONE : ex_csr_waddr_i;
                stall_o         = exc_valid_i | mret_i;
                if (exc_valid_i)  w_next = T_EPC;
                else if (mret_i)  w_next = R_STAT;
            end
            T_EPC: begin
                csr.csr_waddr_o = CSR_MEPC;
                csr.csr_wdata_o = r_pc_q;
                csr.csr_raddr_o = CSR_MSTATUS;
                w_next          = T_CAUSE;
            end
            T_CAUSE: begin
                csr.csr_waddr_o = CSR_MCAUSE;
                csr.csr_wdata_o = {28'h0, r_cause_q};
                csr.csr_raddr_o = CSR_MTVEC;
                w_next          = T_STAT;
            end
            T_STAT: begin
                csr.csr_waddr_o = CSR_MSTATUS;
                csr.csr_wdata_o = w_trap_stat;
                w_next          = T_REDIR;
            end
            T_REDIR: begin
                redirect_o    = 1'b1;
                redirect_pc_o = {r_vec_q[31:2], 2'b00};
                w_next        = IDLE;
            end
            R_STAT: begin
                csr.csr_raddr_o = CSR_MSTATUS;
                w_next          = R_EPC;
            end
            R_EPC: begin
                csr.csr_raddr_o = CSR_MEPC;
                csr.csr_waddr_o = CSR_MSTATUS;
                csr.csr_wdata_o = w_mret_stat;
                w_next          = R_REDIR;
            end
            R_REDIR: begin
                redirect_o    = 1'b1;
                redirect_pc_o = {r_pc_q[31:2], 2'b00};
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase

        // Reset aborts in the same cycle: no further CSR writes and no redirect escape.
        if (rst) begin
            csr.csr_waddr_o = CSR_NONE;
            stall_o         = 1'b0;
            redirect_o      = 1'b0;
            redirect_pc_o   = '0;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a small behavioural CSR file on the interface slave side.
module tb_trap_ctrl;
    localparam logic [11:0] NONE  = 12'h000;
    localparam logic [11:0] MSTAT = 12'h300;
    localparam logic [11:0] MTVEC = 12'h305;
    localparam logic [11:0] MSCR  = 12'h340;
    localparam logic [11:0] MEPC  = 12'h341;
    localparam logic [11:0] MCAU  = 12'h342;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret;
    logic [11:0] ex_raddr;
    logic [11:0] ex_waddr;
    logic [31:0] ex_wdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [0:4095];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid_i    (exc_valid),
        .exc_cause_i    (exc_cause),
        .exc_pc_i       (exc_pc),
        .mret_i         (mret),
        .ex_csr_raddr_i (ex_raddr),
        .ex_csr_waddr_i (ex_waddr),
        .ex_csr_wdata_i (ex_wdata),
        .csr            (bus.master),
        .stall_o        (stall),
        .redirect_o     (redirect),
        .redirect_pc_o  (redirect_pc)
    );

    always #5 clk = ~clk;

    // CSR file: combinational read, posedge write; preload port for bench setup
    assign bus.csr_rdata_i = mem[bus.csr_raddr_o];
    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (bus.csr_waddr_o != NONE)
            mem[bus.csr_waddr_o] <= bus.csr_wdata_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; mret = 1'b0;
        ex_raddr = NONE; ex_waddr = NONE; ex_wdata = '0; pre_en = 1'b0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        cyc(); idle_inputs(); pre_en = 1'b1; pre_addr = a; pre_data = d;
        cyc(); pre_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        pre_addr = '0; pre_data = '0;
        idle_inputs();
        rst = 1'b1;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_redir", {31'b0, redirect}, 32'h0);
        chk("rst_rpc", redirect_pc, 32'h0);
        chk("rst_waddr", {20'b0, bus.csr_waddr_o}, 32'h0);
        cyc(); rst = 1'b0;
        preload(MSTAT, 32'h8);
        preload(MTVEC, 32'h1001);

        // 1 passthrough
        cyc(); ex_raddr = MSCR; ex_waddr = MSCR; ex_wdata = 32'hDEADBEEF; #1;
        chk("pt_waddr", {20'b0, bus.csr_waddr_o}, {20'b0, MSCR});
        chk("pt_wdata", bus.csr_wdata_o, 32'hDEADBEEF);
        chk("pt_raddr", {20'b0, bus.csr_raddr_o}, {20'b0, MSCR});
        chk("pt_stall", {31'b0, stall}, 32'h0);
        chk("pt_redir", {31'b0, redirect}, 32'h0);
        cyc(); idle_inputs(); #1;
        chk("pt_mem", mem[MSCR], 32'hDEADBEEF);

        // 2 trap
        cyc(); exc_valid = 1'b1; exc_cause = 4'd11; exc_pc = 32'h80; #1;
        chk("tr0_stall", {31'b0, stall}, 32'h1);
        chk("tr0_waddr", {20'b0, bus.csr_waddr_o}, 32'h0);
        cyc(); idle_inputs(); #1;
        chk("tr1_waddr", {20'b0, bus.csr_waddr_o}, {20'b0, MEPC});
        chk("tr1_wdata", bus.csr_wdata_o, 32'h80);
        chk("tr1_raddr", {20'b0, bus.csr_raddr_o}, {20'b0, MSTAT});
        chk("tr1_stall", {31'b0, stall}, 32'h1);
        cyc(); #1;
        chk("tr2_waddr", {20'b0, bus.csr_waddr_o}, {20'b0, MCAU});
        chk("tr2_wdata", bus.csr_wdata_o, 32'hB);
        chk("tr2_raddr", {20'b0, bus.csr_raddr_o}, {20'b0, MTVEC});
        cyc(); #1;
        chk("tr3_waddr", {20'b0, bus.csr_waddr_o}, {20'b0, MSTAT});
        chk("tr3_wdata", bus.csr_wdata_o, 32'h1880);
        chk("tr3_redir", {31'b0, redirect}, 32'h0);
        cyc(); #1;
        chk("tr4_redir", {31'b0, redirect}, 32'h1);
        chk("tr4_rpc", redirect_pc, 32'h1000);
        chk("tr4_stall", {31'b0, stall}, 32'h1);
        cyc(); #1;
        chk("tr5_redir", {31'b0, redirect}, 32'h0);
        chk("tr5_stall", {31'b0, stall}, 32'h0);
        chk("tr_mepc", mem[MEPC], 32'h80);
        chk("tr_mcause", mem[MCAU], 32'hB);
        chk("tr_mstatus", mem[MSTAT], 32'h1880);

        // 3 MRET
        preload(MEPC, 32'h86);
        cyc(); mret = 1'b1; #1;
        chk("mr0_stall", {31'b0, stall}, 32'h1);
        chk("mr0_waddr", {20'b0, bus.csr_waddr_o}, 32'h0);
        cyc(); idle_inputs(); #1;
        chk("mr1_waddr", {20'b0, bus.csr_waddr_o}, 32'h0);
        chk("mr1_raddr", {20'b0, bus.csr_raddr_o}, {20'b0, MSTAT});
        cyc(); #1;
        chk("mr2_waddr", {20'b0, bus.csr_waddr_o}, {20'b0, MSTAT});
        chk("mr2_wdata", bus.csr_wdata_o, 32'h1888);
        chk("mr2_raddr", {20'b0, bus.csr_raddr_o}, {20'b0, MEPC});
        cyc(); #1;
        chk("mr3_redir", {31'b0, redirect}, 32'h1);
        chk("mr3_rpc", redirect_pc, 32'h84);
        cyc(); #1;
        chk("mr4_stall", {31'b0, stall}, 32'h0);
        chk("mr4_redir", {31'b0, redirect}, 32'h0);

        // 4 exception + mret + ex write together
        cyc(); exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h200; mret = 1'b1;
        ex_waddr = MEPC; ex_wdata = 32'h5; #1;
        chk("both0_waddr", {20'b0, bus.csr_waddr_o}, 32'h0);
        cyc(); idle_inputs(); #1;
        chk("both1_waddr", {20'b0, bus.csr_waddr_o}, {20'b0, MEPC});
        chk("both1_wdata", bus.csr_wdata_o, 32'h200);
        cyc(); #1;
        chk("both2_wdata", bus.csr_wdata_o, 32'h2);
        cyc(); #1;
        chk("both3_wdata", bus.csr_wdata_o, 32'h1880);
        cyc(); #1;
        chk("both4_rpc", redirect_pc, 32'h1000);
        chk("both4_redir", {31'b0, redirect}, 32'h1);
        cyc(); #1;
        chk("both_mepc", mem[MEPC], 32'h200);

        // 5 reset mid-trap
        preload(MSTAT, 32'h8);
        cyc(); exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h300; #1;
        cyc(); idle_inputs(); #1;
        chk("rs1_waddr", {20'b0, bus.csr_waddr_o}, {20'b0, MEPC});
        cyc(); rst = 1'b1; #1;
        chk("rs2_waddr", {20'b0, bus.csr_waddr_o}, 32'h0);
        chk("rs2_stall", {31'b0, stall}, 32'h0);
        cyc(); rst = 1'b0; #1;
        chk("rs3_stall", {31'b0, stall}, 32'h0);
        chk("rs3_redir", {31'b0, redirect}, 32'h0);
        chk("rs3_waddr", {20'b0, bus.csr_waddr_o}, 32'h0);
        cyc(); #1;
        chk("rs4_redir", {31'b0, redirect}, 32'h0);
        chk("rs_mepc", mem[MEPC], 32'h300);
        chk("rs_mcause", mem[MCAU], 32'h2);
        chk("rs_mstatus", mem[MSTAT], 32'h8);

        // 6 back-to-back
        cyc(); exc_valid = 1'b1; exc_cause = 4'd11; exc_pc = 32'h400; #1;
        cyc(); idle_inputs(); #1;
        chk("bb1_wdata", bus.csr_wdata_o, 32'h400);
        cyc(); exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h500; #1;
        chk("bb2_waddr", {20'b0, bus.csr_waddr_o}, {20'b0, MCAU});
        chk("bb2_wdata", bus.csr_wdata_o, 32'hB);
        cyc(); idle_inputs(); #1;
        chk("bb3_wdata", bus.csr_wdata_o, 32'h1880);
        cyc(); #1;
        chk("bb4_redir", {31'b0, redirect}, 32'h1);
        chk("bb4_rpc", redirect_pc, 32'h1000);
        cyc(); exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h500; #1;
        chk("bb5_stall", {31'b0, stall}, 32'h1);
        chk("bb5_redir", {31'b0, redirect}, 32'h0);
        chk("bb5_waddr", {20'b0, bus.csr_waddr_o}, 32'h0);
        cyc(); idle_inputs(); #1;
        chk("bb6_waddr", {20'b0, bus.csr_waddr_o}, {20'b0, MEPC});
        chk("bb6_wdata", bus.csr_wdata_o, 32'h500);
        cyc(); #1;
        chk("bb7_wdata", bus.csr_wdata_o, 32'h3);
        cyc(); cyc(); #1;
        chk("bb9_redir", {31'b0, redirect}, 32'h1);
        cyc(); #1;
        chk("bb10_stall", {31'b0, stall}, 32'h0);
        chk("bb_mepc", mem[MEPC], 32'h500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
